// File: rtl/rc_pwm_transmitter.sv
`default_nettype none
// ============================================================================
//  Module      : rc_pwm_transmitter
//  Description : Seven-channel RC servo-format PWM transmitter. Each channel
//                value (8 bits) becomes a pulse of
//                MIN_PULSE_US + (val << STEP_SHIFT) us, and the pulse repeats
//                every FRAME_US us. One us_clk cycle is one microsecond.
//
//  Ports
//    us_clk            in   1  1 MHz clock, single domain
//    reset             in   1  asynchronous, active-high reset
//    enable            in   1  frames are generated while high
//    load_strobe       in   1  captures all *_val inputs into the shadow set
//    *_val (x7)        in   8  channel values
//    *_pwm (x7)        out  1  registered pulse outputs
//    frame_strobe      out  1  one-cycle pulse marking a frame start
//    active            out  1  high while frames are being produced
//
//  Revision    : 1.0  initial release
// ============================================================================
module rc_pwm_transmitter #(
    parameter int FRAME_US     = 20000,
    parameter int MIN_PULSE_US = 1000,
    parameter int STEP_SHIFT   = 2
) (
    input  logic       us_clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       load_strobe,
    input  logic [7:0] throttle_val,
    input  logic [7:0] yaw_val,
    input  logic [7:0] roll_val,
    input  logic [7:0] pitch_val,
    input  logic [7:0] aux1_val,
    input  logic [7:0] aux2_val,
    input  logic [7:0] swa_swb_val,
    output logic       throttle_pwm,
    output logic       yaw_pwm,
    output logic       roll_pwm,
    output logic       pitch_pwm,
    output logic       aux1_pwm,
    output logic       aux2_pwm,
    output logic       swa_swb_pwm,
    output logic       frame_strobe,
    output logic       active
);

    localparam int          c_num_ch    = 7;
    localparam int          c_cnt_w     = 15;
    localparam int          c_pw_w      = 11;
    localparam logic [14:0] c_last_cnt  = 15'(FRAME_US - 1);
    localparam logic [10:0] c_min_pulse = 11'(MIN_PULSE_US);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                              r_state;
    state_t                              w_state_next;
    logic [c_cnt_w-1:0]                  r_frame_cnt;
    logic [c_cnt_w-1:0]                  w_frame_cnt_next;
    logic                                w_frame_start;

    // Channel index 0 is throttle, 6 is swa_swb.
    logic [c_num_ch-1:0][7:0]            w_val;
    logic [c_num_ch-1:0][7:0]            r_shadow;
    logic [c_num_ch-1:0][c_pw_w-1:0]     w_width_new;
    logic [c_num_ch-1:0][c_pw_w-1:0]     r_width;
    logic [c_num_ch-1:0]                 r_pwm;
    logic                                r_frame_strobe;
    logic                                r_active;

    assign w_val = {swa_swb_val, aux2_val, aux1_val, pitch_val,
                    roll_val, yaw_val, throttle_val};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge us_clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_frame_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_frame_cnt <= w_frame_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / frame counter logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next     = r_state;
        w_frame_cnt_next = r_frame_cnt;
        w_frame_start    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_frame_cnt_next = '0;
                if (enable) begin
                    // The enabling cycle itself is the first frame start,
                    // so it plays the role of frame_cnt == 0.
                    w_state_next     = ST_RUN;
                    w_frame_start    = 1'b1;
                    w_frame_cnt_next = 15'd1;
                end
            end
            ST_RUN: begin
                w_frame_start = (r_frame_cnt == '0);
                if (r_frame_cnt == c_last_cnt) begin
                    // Decision point: a frame is always finished before
                    // leaving, and re-enabling during the draining frame
                    // simply continues without a gap.
                    w_frame_cnt_next = '0;
                    if (!enable) begin
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_frame_cnt_next = r_frame_cnt + 15'd1;
                end
            end
            default: begin
                w_state_next     = ST_IDLE;
                w_frame_cnt_next = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pulse-width arithmetic from the shadow set
    // ------------------------------------------------------------------
    always_comb begin
        w_width_new = '0;
        for (int i = 0; i < c_num_ch; i++) begin
            w_width_new[i] = c_min_pulse + (11'(r_shadow[i]) << STEP_SHIFT);
        end
    end

    // ------------------------------------------------------------------
    // Shadow registers. A strobe coinciding with a frame start still
    // updates here, while the active set samples the old contents on the
    // same edge, so new values take effect one frame later.
    // ------------------------------------------------------------------
    always_ff @(posedge us_clk or posedge reset) begin
        if (reset) begin
            r_shadow <= '0;
        end else if (load_strobe) begin
            r_shadow <= w_val;
        end
    end

    // ------------------------------------------------------------------
    // Active widths and pulse outputs
    // ------------------------------------------------------------------
    always_ff @(posedge us_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_num_ch; i++) begin
                r_width[i] <= c_min_pulse;
            end
            r_pwm <= '0;
        end else begin
            for (int i = 0; i < c_num_ch; i++) begin
                if (w_frame_start) begin
                    r_width[i] <= w_width_new[i];
                    r_pwm[i]   <= 1'b1;
                end else if (r_state != ST_RUN) begin
                    r_pwm[i]   <= 1'b0;
                end else if (15'(r_width[i]) == r_frame_cnt) begin
                    // Output rose after frame_cnt 0, so dropping here
                    // leaves it high for exactly r_width cycles.
                    r_pwm[i]   <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Status outputs
    // ------------------------------------------------------------------
    always_ff @(posedge us_clk or posedge reset) begin
        if (reset) begin
            r_frame_strobe <= 1'b0;
            r_active       <= 1'b0;
        end else begin
            r_frame_strobe <= w_frame_start;
            r_active       <= (w_state_next == ST_RUN);
        end
    end

    assign throttle_pwm = r_pwm[0];
    assign yaw_pwm      = r_pwm[1];
    assign roll_pwm     = r_pwm[2];
    assign pitch_pwm    = r_pwm[3];
    assign aux1_pwm     = r_pwm[4];
    assign aux2_pwm     = r_pwm[5];
    assign swa_swb_pwm  = r_pwm[6];
    assign frame_strobe = r_frame_strobe;
    assign active       = r_active;

endmodule
`default_nettype wire

// File: tb/tb_rc_pwm_transmitter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rc_pwm_transmitter
//  Description : Self-checking bench for rc_pwm_transmitter. A shortened
//                frame period keeps run time low while pulse widths keep
//                their real 1000..2020 us range.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rc_pwm_transmitter;

    localparam int FRAME = 2500;
    localparam int MINP  = 1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       load = 1'b0;
    logic [7:0] vals [7];
    logic [6:0] pwm;
    logic       frame_strobe;
    logic       active;

    int total = 0;
    int bad   = 0;

    int m_w [7];
    int m_act;
    int m_strb;

    typedef struct packed {
        logic [6:0][7:0]  val;
        logic [6:0][11:0] w;
    } vec_t;

    vec_t tbl [4];

    always #5 clk = ~clk;

    rc_pwm_transmitter #(
        .FRAME_US    (FRAME),
        .MIN_PULSE_US(MINP),
        .STEP_SHIFT  (2)
    ) dut (
        .us_clk      (clk),
        .reset       (rst),
        .enable      (enable),
        .load_strobe (load),
        .throttle_val(vals[0]),
        .yaw_val     (vals[1]),
        .roll_val    (vals[2]),
        .pitch_val   (vals[3]),
        .aux1_val    (vals[4]),
        .aux2_val    (vals[5]),
        .swa_swb_val (vals[6]),
        .throttle_pwm(pwm[0]),
        .yaw_pwm     (pwm[1]),
        .roll_pwm    (pwm[2]),
        .pitch_pwm   (pwm[3]),
        .aux1_pwm    (pwm[4]),
        .aux2_pwm    (pwm[5]),
        .swa_swb_pwm (pwm[6]),
        .frame_strobe(frame_strobe),
        .active      (active)
    );

    function automatic vec_t mk(input int v0, v1, v2, v3, v4, v5, v6,
                                input int w0, w1, w2, w3, w4, w5, w6);
        vec_t r;
        r.val[0] = 8'(v0); r.val[1] = 8'(v1); r.val[2] = 8'(v2);
        r.val[3] = 8'(v3); r.val[4] = 8'(v4); r.val[5] = 8'(v5);
        r.val[6] = 8'(v6);
        r.w[0] = 12'(w0); r.w[1] = 12'(w1); r.w[2] = 12'(w2);
        r.w[3] = 12'(w3); r.w[4] = 12'(w4); r.w[5] = 12'(w5);
        r.w[6] = 12'(w6);
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_strobe(input string name);
        int n;
        n = 0;
        while (!frame_strobe && n < FRAME + 20) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(frame_strobe), 1);
    endtask

    // Starts on the negedge where frame_strobe is visible and spans exactly
    // one frame period, ending on the negedge where the next strobe is due.
    task automatic measure(input int drop_at, input int rise_at);
        for (int c = 0; c < 7; c++) m_w[c] = 0;
        m_act  = 0;
        m_strb = 0;
        for (int j = 0; j < FRAME; j++) begin
            for (int c = 0; c < 7; c++) if (pwm[c]) m_w[c]++;
            if (active) m_act++;
            if (frame_strobe) m_strb++;
            if (j == drop_at) enable = 1'b0;
            if (j == rise_at) enable = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic check_widths(input string tag, input vec_t v);
        for (int c = 0; c < 7; c++)
            check($sformatf("%s width ch%0d", tag, c), m_w[c], int'(v.w[c]));
    endtask

    task automatic check_all(input string tag, input int w);
        for (int c = 0; c < 7; c++)
            check($sformatf("%s width ch%0d", tag, c), m_w[c], w);
    endtask

    initial begin
        vec_t cur;
        int   idle_strb;
        int   idle_pwm;

        for (int c = 0; c < 7; c++) vals[c] = 8'd0;

        // throttle, yaw, roll, pitch, aux1, aux2, swa_swb ; widths
        tbl[0] = mk(0, 255, 128, 64, 64, 64, 64,
                    1000, 2020, 1512, 1256, 1256, 1256, 1256);
        tbl[1] = mk(64, 128, 255, 0, 1, 2, 3,
                    1256, 1512, 2020, 1000, 1004, 1008, 1012);
        tbl[2] = mk(255, 0, 64, 128, 200, 100, 50,
                    2020, 1000, 1256, 1512, 1800, 1400, 1200);
        tbl[3] = mk(128, 64, 0, 255, 254, 127, 129,
                    1512, 1256, 1000, 2020, 2016, 1508, 1516);

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("reset pwm", int'(pwm), 0);
        check("reset strobe", int'(frame_strobe), 0);
        check("reset active", int'(active), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle pwm", int'(pwm), 0);
        check("idle active", int'(active), 0);

        // ---------------- enable latency + reset defaults ----------------
        enable = 1'b1;
        @(negedge clk);
        check("start strobe", int'(frame_strobe), 1);
        check("start active", int'(active), 1);
        check("start pwm", int'(pwm), 127);
        measure(-1, -1);
        check_all("default", 1000);
        check("default strobes/frame", m_strb, 1);
        check("default active cycles", m_act, FRAME);
        check("strobe period", int'(frame_strobe), 1);

        // ---------------- table: loads mid-frame, last strobe wins -------
        for (int k = 0; k < 4; k++) begin
            repeat (100) @(negedge clk);
            for (int c = 0; c < 7; c++) vals[c] = tbl[k].val[c] ^ 8'h5A;
            load = 1'b1;
            @(negedge clk);
            for (int c = 0; c < 7; c++) vals[c] = tbl[k].val[c];
            @(negedge clk);
            load = 1'b0;
            wait_strobe($sformatf("vec%0d strobe", k));
            measure(-1, -1);
            check_widths($sformatf("vec%0d", k), tbl[k]);
            check($sformatf("vec%0d strobes/frame", k), m_strb, 1);
            for (int c = 0; c < 7; c++) begin
                int dec;
                int diff;
                dec  = (m_w[c] - MINP) >>> 2;
                diff = dec - int'(tbl[k].val[c]);
                total++;
                if (diff > 1 || diff < -1) begin
                    bad++;
                    $display("FAIL vec%0d decode ch%0d: got %0d, expected %0d",
                             k, c, dec, tbl[k].val[c]);
                end
            end
        end

        // ---------------- coincident load ----------------
        // At the strobe negedge frame_cnt is 1; FRAME-1 cycles later it is 0.
        repeat (FRAME - 1) @(negedge clk);
        vals[0] = 8'd200;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("coincident strobe", int'(frame_strobe), 1);
        measure(-1, -1);
        check_widths("coincident old", tbl[3]);
        cur = tbl[3];
        cur.w[0] = 12'd1800;
        measure(-1, -1);
        check_widths("coincident new", cur);

        // ---------------- enable drop at frame_cnt 500 ----------------
        measure(499, -1);
        check_widths("drain", cur);
        check("drain active cycles", m_act, FRAME - 1);
        check("drain end strobe", int'(frame_strobe), 0);
        check("drain end active", int'(active), 0);
        idle_strb = 0;
        idle_pwm  = 0;
        repeat (FRAME + 10) begin
            if (frame_strobe) idle_strb++;
            if (pwm != 7'd0 || active) idle_pwm++;
            @(negedge clk);
        end
        check("post-drain strobes", idle_strb, 0);
        check("post-drain busy cycles", idle_pwm, 0);

        // ---------------- load while idle ----------------
        for (int c = 0; c < 7; c++) vals[c] = 8'd10;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        check("idle-load start strobe", int'(frame_strobe), 1);
        measure(-1, -1);
        check_all("idle-load", 1040);

        // ---------------- re-enable during draining frame ----------------
        measure(499, 1499);
        check_all("re-enable", 1040);
        check("re-enable active cycles", m_act, FRAME);
        check("re-enable no gap", int'(frame_strobe), 1);

        // ---------------- reset mid-pulse at frame_cnt 700 ----------------
        repeat (699) @(negedge clk);
        check("pre-reset pwm", int'(pwm), 127);
        rst = 1'b1;
        #1;
        check("async reset pwm", int'(pwm), 0);
        check("async reset active", int'(active), 0);
        check("async reset strobe", int'(frame_strobe), 0);
        @(negedge clk);
        rst = 1'b0;
        wait_strobe("post-reset strobe");
        measure(-1, -1);
        check_all("post-reset", 1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rc_pwm_transmitter.md
# rc_pwm_transmitter

Seven-channel RC-style PWM transmitter. It does the reverse of the `receiver` block: it converts 8-bit channel values into servo-format pulses of 1000–2020 us, repeated every 20 ms. It runs on `us_clk`, so one cycle is 1 us. It is used as a hardware-in-the-loop stimulus source for the flight stack (looped back onto the receiver pins) and as the driver for a downstream servo/gimbal header.

## Interface
Parameters:
- `FRAME_US`, default 20000: frame period in `us_clk` cycles.
- `MIN_PULSE_US`, default 1000: pulse width for a value of 0.
- `STEP_SHIFT`, default 2: pulse width = `MIN_PULSE_US + (val << STEP_SHIFT)`.

Constraint: `MIN_PULSE_US + (255 << STEP_SHIFT) < FRAME_US`.

Ports:
- `us_clk`, in, 1: 1 MHz clock. One clock; all logic is in this domain.
- `reset`, in, 1: asynchronous, active-high reset.
- `enable`, in, 1: level. Frames are generated while it is high.
- `load_strobe`, in, 1: one-cycle pulse. Captures all seven `*_val` inputs into the shadow registers.
- `throttle_val`, `yaw_val`, `roll_val`, `pitch_val`, `aux1_val`, `aux2_val`, `swa_swb_val`: in, 8 each. Channel values.
- `throttle_pwm`, `yaw_pwm`, `roll_pwm`, `pitch_pwm`, `aux1_pwm`, `aux2_pwm`, `swa_swb_pwm`: out, 1 each. Registered pulse outputs.
- `frame_strobe`, out, 1: one-cycle pulse in the frame-start cycle.
- `active`, out, 1: high from the first frame start until the end of the last frame after `enable` drops.

## Operation
Registers:
- Shadow register set: 7 x 8 bits, written only on `load_strobe`.
- Active register set: 7 x 11-bit pulse widths, computed from the shadow values and loaded only in the frame-start cycle.

`frame_cnt` (15 bits) counts from 0 to `FRAME_US-1` and then wraps to 0. A frame-start cycle is any cycle with `frame_cnt == 0` while in RUN.

State machine:
- **IDLE**: `frame_cnt` held at 0, all pwm outputs 0, `active` = 0. When `enable` is 1, go to RUN; that same cycle is the first frame-start cycle.
- **RUN**: `frame_cnt` increments every cycle. In the frame-start cycle:
  - active widths are loaded from the shadow registers;
  - `frame_strobe` = 1;
  - every channel output is set high (visible on the next cycle).
- Each channel output goes low on the cycle where `frame_cnt` equals that channel's width.
- When `frame_cnt == FRAME_US-1`: if `enable` is 0, go to IDLE; otherwise wrap to 0 and stay in RUN.
- Dropping `enable` mid-frame does not truncate pulses. The current frame always completes.

Width arithmetic is unsigned: `MIN_PULSE_US + {val, STEP_SHIFT zeros}`, 11 bits, no saturation needed. Value 0 gives 1000 us; value 255 gives 2020 us.

Boundary rules:
- `load_strobe` in the frame-start cycle: the shadow registers update, but the active widths take the pre-strobe shadow values. The new values apply from the next frame.
- `load_strobe` while in IDLE updates the shadow registers normally.
- Back-to-back `load_strobe` pulses: the last one before a frame start wins.
- `enable` re-asserted during the final (draining) frame: no gap. The next frame starts at the wrap, as in continuous RUN.
- `reset` mid-pulse: all outputs go to 0 asynchronously, the state returns to IDLE, and no partial pulse completes.

## Timing
Reset values:
- All pwm outputs, `frame_strobe`, `active`: 0.
- Shadow registers: 0.
- Active widths: `MIN_PULSE_US`.
- `frame_cnt`: 0.
- State: IDLE.

Latency and cycle relationships:
- `enable` rising at cycle T (sampled in IDLE): `frame_strobe` = 1 during T+1, and pwm outputs and `active` are high from T+1.
- Each pwm output is high for exactly `width` cycles per frame.
- `frame_strobe` period is exactly `FRAME_US` cycles.
- `load_strobe` at cycle L in RUN: the values appear at the first frame start strictly after L.
- `active` falls in the cycle after `frame_cnt == FRAME_US-1` with `enable` = 0.

## Test plan
- **Reset defaults**: `enable`=1 with no load. Expect all seven outputs high for 1000 cycles per frame and `frame_strobe` every 20000 cycles.
- **Value extremes**: load throttle=0, yaw=255, roll=128, others=64. Next frame widths must be 1000, 2020, 1512 and 1256 cycles respectively.
- **Coincident load**: `load_strobe` with throttle=200 exactly in a frame-start cycle. That frame's throttle pulse must be the old width; the following frame must be 1800 us.
- **Enable drop**: deassert `enable` at `frame_cnt`=500. The current pulses must complete at full width, `active` must fall at the frame end, and no further `frame_strobe` may occur.
- **Reset mid-pulse**: assert `reset` at `frame_cnt`=700. All outputs must be 0 that same cycle. After release with `enable`=1, widths must be back to 1000 us.
- **Loopback**: connect the outputs to `receiver`, sweep values 0, 64, 128, 255. The decoded `*_val` outputs must match within ±1 LSB.
